// File: rtl/fpu_add_driver.sv
`default_nettype none
// ============================================================================
// Module   : fpu_add_driver
// Brief    : Initiator-side sequencer for the single-precision FP adder
//            handshake, with valid/ready request/result ports and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_add_driver #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_z,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count,
    output logic             fpu_rst,
    output logic             fpu_start,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic             fpu_a_ack,
    input  logic             fpu_b_ack,
    input  logic [31:0]      fpu_z,
    input  logic             fpu_z_stb,
    output logic             fpu_ack,
    input  logic             fpu_valid,
    input  logic             fpu_idle
);

    localparam int c_wd_clog = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_wd_w    = (c_wd_clog > 8) ? c_wd_clog : 8;
    localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       c_qnan     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_RST1   = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_WAIT_A = 3'd3,
        S_WAIT_B = 3'd4,
        S_WAIT_Z = 3'd5,
        S_WAIT_V = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t            r_state;
    logic [c_wd_w-1:0] r_wd;
    logic              w_wait;
    logic              w_event;
    logic              w_abort;

    assign req_ready = (r_state == S_IDLE) & fpu_idle & ~fpu_rst;

    // The awaited input of the current wait state; it beats a same-cycle expiry.
    always_comb begin
        w_event = 1'b0;
        case (r_state)
            S_WAIT_A: w_event = fpu_a_ack;
            S_WAIT_B: w_event = fpu_b_ack;
            S_WAIT_Z: w_event = fpu_z_stb;
            S_WAIT_V: w_event = fpu_valid;
            default:  w_event = 1'b0;
        endcase
    end

    assign w_wait  = (r_state == S_WAIT_A) || (r_state == S_WAIT_B) ||
                     (r_state == S_WAIT_Z) || (r_state == S_WAIT_V);
    assign w_abort = w_wait & (r_wd == c_wd_limit) & ~w_event;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_RST1;
            r_wd      <= '0;
            fpu_rst   <= 1'b1;
            fpu_start <= 1'b0;
            fpu_ack   <= 1'b0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            res_valid <= 1'b0;
            res_z     <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
            txn_count <= '0;
        end else begin
            if (w_wait && !w_event && !w_abort) begin
                r_wd <= r_wd + c_wd_w'(1);
            end else begin
                r_wd <= '0;
            end

            if (w_abort) begin
                fpu_ack   <= 1'b0;
                fpu_rst   <= 1'b1;
                res_z     <= c_qnan;
                res_err   <= 1'b1;
                res_valid <= 1'b1;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_RST1: begin
                        fpu_rst <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (req_valid && req_ready) begin
                            fpu_a     <= req_a;
                            fpu_b     <= req_b;
                            res_tag   <= req_tag;
                            fpu_start <= 1'b1;
                            busy      <= 1'b1;
                            r_state   <= S_START;
                        end
                    end
                    S_START: begin
                        fpu_start <= 1'b0;
                        r_state   <= S_WAIT_A;
                    end
                    S_WAIT_A: begin
                        if (fpu_a_ack) r_state <= S_WAIT_B;
                    end
                    S_WAIT_B: begin
                        if (fpu_b_ack) r_state <= S_WAIT_Z;
                    end
                    S_WAIT_Z: begin
                        if (fpu_z_stb) begin
                            res_z   <= fpu_z;
                            fpu_ack <= 1'b1;
                            r_state <= S_WAIT_V;
                        end
                    end
                    S_WAIT_V: begin
                        // Dropping ack on the same edge lets the adder see valid&ack once.
                        if (fpu_valid) begin
                            fpu_ack   <= 1'b0;
                            res_valid <= 1'b1;
                            res_err   <= 1'b0;
                            txn_count <= txn_count + CNT_W'(1);
                            r_state   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        fpu_rst <= 1'b0;
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_RST1;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_add_driver
// Brief    : Directed-vector scoreboard bench with a handshake model of the adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_add_driver;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [31:0]      res_z;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;
    logic [CNT_W-1:0] txn_count;
    logic             fpu_rst;
    logic             fpu_start;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic             fpu_a_ack = 1'b0;
    logic             fpu_b_ack = 1'b0;
    logic [31:0]      fpu_z = '0;
    logic             fpu_z_stb = 1'b0;
    logic             fpu_ack;
    logic             fpu_valid = 1'b0;
    logic             fpu_idle = 1'b0;

    always #5 clk = ~clk;

    fpu_add_driver #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_tag(res_tag), .res_err(res_err),
        .busy(busy), .txn_count(txn_count),
        .fpu_rst(fpu_rst), .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_a_ack(fpu_a_ack), .fpu_b_ack(fpu_b_ack), .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb),
        .fpu_ack(fpu_ack), .fpu_valid(fpu_valid), .fpu_idle(fpu_idle)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-computed sums for the directed operand pairs.
    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3FC00000, 32'hBFC00000}: return 32'h00000000;
            {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
            {32'h40A00000, 32'h40400000}: return 32'h41000000;
            {32'h41200000, 32'h3F800000}: return 32'h41300000;
            {32'hBF800000, 32'hBF800000}: return 32'hC0000000;
            {32'h40800000, 32'h40800000}: return 32'h41000000;
            {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Adder handshake model
    typedef enum int {M_RST, M_IDLE, M_A, M_B, M_CALC, M_STB, M_VAL} mstate_t;
    mstate_t     m_state = M_RST;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          m_calc = 0;
    bit          stall_mode = 1'b0;

    always @(posedge clk) begin
        if (fpu_rst) begin
            m_state   <= M_RST;
            fpu_a_ack <= 1'b0;
            fpu_b_ack <= 1'b0;
            fpu_z_stb <= 1'b0;
            fpu_valid <= 1'b0;
            fpu_idle  <= 1'b0;
        end else begin
            case (m_state)
                M_RST:  begin fpu_idle <= 1'b1; m_state <= M_IDLE; end
                M_IDLE: if (fpu_start) begin fpu_idle <= 1'b0; fpu_a_ack <= 1'b1; m_state <= M_A; end
                M_A:    begin m_a <= fpu_a; fpu_a_ack <= 1'b0; fpu_b_ack <= 1'b1; m_state <= M_B; end
                M_B:    begin m_b <= fpu_b; fpu_b_ack <= 1'b0; m_calc <= 1 + int'(fpu_b[23]) * 2; m_state <= M_CALC; end
                M_CALC: if (!stall_mode) begin
                            if (m_calc == 0) begin
                                fpu_z     <= model_sum(m_a, m_b);
                                fpu_z_stb <= 1'b1;
                                m_state   <= M_STB;
                            end else begin
                                m_calc <= m_calc - 1;
                            end
                        end
                M_STB:  if (fpu_ack) begin fpu_z_stb <= 1'b0; fpu_valid <= 1'b1; m_state <= M_VAL; end
                M_VAL:  if (fpu_ack && fpu_valid) begin fpu_valid <= 1'b0; fpu_idle <= 1'b1; m_state <= M_IDLE; end
                default: m_state <= M_RST;
            endcase
        end
    end

    typedef struct {
        logic [31:0]      z;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [CNT_W-1:0] txn;
        int               ack;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: protocol properties every cycle, scoreboard pop on each accepted result.
    int               rst_run = 0;
    int               ack_cnt = 0;
    int               start_cnt = 0;
    bit               prev_start = 1'b0;
    int               last_b_cyc = 0;
    int               last_rst_rise = 0;
    bit               held = 1'b0;
    logic [31:0]      h_z;
    logic [TAG_W-1:0] h_tag;
    logic             h_err;

    always @(negedge clk) begin
        if (!rst) begin
            rst_run    = 0;
            ack_cnt    = 0;
            held       = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (fpu_rst) begin
                rst_run++;
                if (rst_run == 1) last_rst_rise = cyc;
            end else if (rst_run != 0) begin
                chk("fpu_rst_width", 32'(rst_run), 32'd1);
                rst_run = 0;
            end
            if (fpu_start) begin
                if (prev_start) chk("fpu_start_twice", 32'd1, 32'd0);
                start_cnt++;
                ack_cnt = 0;
            end
            prev_start = fpu_start;
            if (fpu_ack) ack_cnt++;
            if (fpu_b_ack) last_b_cyc = cyc;
            if (req_ready) chk("ready_needs_idle", 32'(fpu_idle), 32'd1);
            if (res_valid) chk("ready_while_done", 32'(req_ready), 32'd0);
            if (held) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_z", res_z, h_z);
                chk("hold_tag", 32'(res_tag), 32'(h_tag));
                chk("hold_err", 32'(res_err), 32'(h_err));
            end
            held  = res_valid && !res_ready;
            h_z   = res_z;
            h_tag = res_tag;
            h_err = res_err;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_z", res_z, e.z);
                    chk("res_tag", 32'(res_tag), 32'(e.tag));
                    chk("res_err", 32'(res_err), 32'(e.err));
                    chk("txn_count", 32'(txn_count), 32'(e.txn));
                    chk("ack_cycles", 32'(ack_cnt), 32'(e.ack));
                end
            end
        end
    end

    logic [CNT_W-1:0] exp_txn = '0;

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp_z, input logic exp_err, input bit push);
        int n = 0;
        exp_t e;
        while (!req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (push) begin
            if (!exp_err) exp_txn = exp_txn + CNT_W'(1);
            e.z   = exp_z;
            e.tag = tag;
            e.err = exp_err;
            e.txn = exp_txn;
            e.ack = exp_err ? 0 : 2;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_fpu_rst"}, 32'(fpu_rst), 32'd1);
        chk({tag, "_fpu_start"}, 32'(fpu_start), 32'd0);
        chk({tag, "_fpu_ack"}, 32'(fpu_ack), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_err"}, 32'(res_err), 32'd0);
        chk({tag, "_res_z"}, res_z, 32'd0);
        chk({tag, "_res_tag"}, 32'(res_tag), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_txn_count"}, 32'(txn_count), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_fpu_a"}, fpu_a, 32'd0);
        chk({tag, "_fpu_b"}, fpu_b, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        send(32'h3F800000, 32'h40000000, 4'd3, 32'h40400000, 1'b0, 1'b1);
        drain();
        send(32'h3FC00000, 32'hBFC00000, 4'd5, 32'h00000000, 1'b0, 1'b1);
        drain();
        send(32'h7F800000, 32'h3F800000, 4'd6, 32'h7F800000, 1'b0, 1'b1);
        drain();

        // Back-to-back with the second result held by the consumer for 10 cycles.
        send(32'h40A00000, 32'h40400000, 4'd1, 32'h41000000, 1'b0, 1'b1);
        drain();
        res_ready = 1'b0;
        send(32'h41200000, 32'h3F800000, 4'd2, 32'h41300000, 1'b0, 1'b1);
        n = 0;
        while (!res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("res_valid_timeout", 32'd0, 32'd1);
        repeat (10) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        send(32'hBF800000, 32'hBF800000, 4'd7, 32'hC0000000, 1'b0, 1'b1);
        drain();
        chk("txn_after_b2b", 32'(txn_count), 32'd6);

        // Stalled adder: watchdog abort in WAIT_Z.
        stall_mode = 1'b1;
        send(32'h40000000, 32'h40000000, 4'd4, 32'h7FC00000, 1'b1, 1'b1);
        drain();
        stall_mode = 1'b0;
        chk("timeout_cycles", 32'(last_rst_rise - last_b_cyc), 32'(TIMEOUT + 1));
        chk("txn_after_abort", 32'(txn_count), 32'd6);
        send(32'h40800000, 32'h40800000, 4'd8, 32'h41000000, 1'b0, 1'b1);
        drain();

        // Asynchronous reset during WAIT_V.
        send(32'h3F000000, 32'h3F000000, 4'd9, 32'h3F800000, 1'b0, 1'b0);
        n = 0;
        while (!fpu_ack && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("wait_v_timeout", 32'd0, 32'd1);
        #2 rst = 1'b0;
        #1 check_reset("midrst");
        exp_txn = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_stale_valid", 32'(res_valid), 32'd0);
        end
        send(32'h40400000, 32'h3F800000, 4'd10, 32'h40800000, 1'b0, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("start_pulses", 32'(start_cnt), 32'd10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
